spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised SPI master for the SD-card/audio-video peripheral: the next generation of the fixed 8-bit
//  mode-3 shifter. Generates SCLK from the system clock via a runtime divider, supports all 4 CPOL/CPHA
//  modes, any word width, MSB/LSB-first, drives chip-select and holds CS across words on request.
//  Valid/ready word handshake toward the SD command/data engine; full-duplex (one Rx word per Tx word).
// PARAMETERS
//  DATA_W    8   bits per SPI word (2..32)
//  DIV_W     8   width of ClkDiv input
//  CPOL      1   SCLK idle level
//  CPHA      1   0: sample leading edge / shift trailing; 1: shift leading / sample trailing
//  MSB_FIRST 1   1: bit DATA_W-1 first; 0: bit 0 first
// PORTS
//  CLK       in   1       system clock, all logic on posedge
//  RST       in   1       asynchronous, active-high reset
//  ClkDiv    in   DIV_W   SCLK half-period = ClkDiv+1 CLK cycles; sampled on Tx accept
//  CsHold    in   1       1: keep SPI_CS_n low after word, await next word
//  TxData    in   DATA_W  word to send
//  TxValid   in   1       word request
//  TxReady   out  1       block can accept a word (IDLE or HOLD)
//  RxData    out  DATA_W  last received word, stable until next RxValid
//  RxValid   out  1       one-cycle pulse: RxData updated
//  Busy      out  1       high whenever SPI_CS_n low or state != IDLE
//  SPI_CS_n  out  1       chip select, active low
//  SPI_CLK   out  1       serial clock, registered
//  SPI_MOSI  out  1       serial data out, registered
//  SPI_MISO  in   1       serial data in (sampled on the SCLK sample edge via CLK)
// BEHAVIOUR
//  Reset (async, immediate, also mid-transfer): state IDLE, SPI_CS_n=1, SPI_CLK=CPOL, SPI_MOSI=1,
//   RxData=0, RxValid=0, Busy=0, TxReady=1 once RST deasserts. Partial word discarded, no RxValid.
//  Let H=ClkDiv+1 (latched). Transfer accepted on cycle where TxValid&&TxReady; TxData latched same edge.
//  FSM:
//   IDLE  -accept-> LEAD: SPI_CS_n=0 next cycle; CPHA=0 drives first bit on MOSI now. Lasts H cycles.
//   LEAD  -> XFER: 2*DATA_W SCLK edges, one every H cycles; SCLK toggles, first edge leaves CPOL.
//          Shift edge updates MOSI (except first bit when CPHA=0); sample edge captures MISO into shreg.
//   XFER  after last edge: RxData<=shreg, RxValid=1 next cycle; SCLK back at CPOL.
//          CsHold=1 -> HOLD; else -> TRAIL.
//   HOLD  CS low, SCLK=CPOL, MOSI=1, TxReady=1. Accept -> LEAD-less gap of H cycles then XFER.
//          CsHold=0 with no TxValid -> TRAIL. Simultaneous accept and CsHold=0: accept wins.
//   TRAIL CS low for H cycles, then SPI_CS_n=1 and IDLE. TxReady=0 in TRAIL (CS min-high guaranteed by
//          one IDLE cycle before next LEAD).
//  Word latency (IDLE start, CsHold=0): CS low 1 cycle after accept; RxValid at 1+H+2*DATA_W*H cycles;
//   back to IDLE after H more.
//  ClkDiv=0: H=1, SCLK=CLK/2 (max rate). ClkDiv=all-ones legal. ClkDiv changes mid-word ignored.
//  Bit counter counts 0..2*DATA_W-1, no wrap within word; edge counter reset per word.
//  TxValid while TxReady=0: held off, no data loss (TxData must stay stable per valid/ready rule).
// STRUCTURE
//  Shared package/include spi_pkg: FSM state encoding (IDLE,LEAD,XFER,HOLD,TRAIL), mode constants
//   SPI_MODE0..3 as {CPOL,CPHA}.
//  Sub-module spi_clk_tick: DIV_W down-counter, reload H, emits 1-cycle edge tick; enabled in LEAD/XFER/
//   HOLD-gap/TRAIL. Remaining logic (FSM, shift regs, outputs) in this module.
// TESTING
//  1 Mode 3, DATA_W=8, ClkDiv=0, TxData=8'hA5, MISO loopback -> MOSI bits 1,0,1,0,0,1,0,1; RxData=8'hA5,
//    RxValid one pulse at cycle 1+1+16=18 after accept; CS high again at cycle 19.
//  2 All 4 modes, ClkDiv=3, TxData=8'h3C, slave model returns 8'hC3 -> RxData=8'hC3, SCLK idle=CPOL,
//    each SCLK level lasts exactly 4 cycles.
//  3 CsHold=1, 3 words 8'h01,8'h02,8'h03 back-to-back -> SPI_CS_n low continuously, 3 RxValid pulses,
//    CS rises H cycles after 3rd word once CsHold=0.
//  4 RST asserted mid-word (after 5 SCLK edges) -> same cycle CS_n=1, SCLK=CPOL, MOSI=1; no RxValid;
//    next word after reset completes correctly.
//  5 DATA_W=16, MSB_FIRST=0, TxData=16'h8001 -> first and last MOSI bit 1, 14 zeros between.
//  6 TxValid held high in TRAIL -> not accepted until IDLE; CS high for >=1 cycle between words.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the parametrised SPI master.
//   - FSM state encoding (kept as plain localparams for older tooling)
//   - SPI mode constants as {CPOL, CPHA}
package spi_pkg;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_LEAD  = 3'd1;
  localparam spi_state_t ST_XFER  = 3'd2;
  localparam spi_state_t ST_HOLD  = 3'd3;
  localparam spi_state_t ST_TRAIL = 3'd4;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: SCLK edge timebase for spi_master_param.
//   A down-counter that emits a one-cycle tick every (div+1) enabled cycles.
// Ports:
//   CLK      system clock
//   RST      asynchronous active-high reset
//   en       count enable (LEAD/gap, XFER, TRAIL)
//   load     latch a new divider from div and restart the count
//   restart  restart the count from the already latched divider
//   div      divider value (half-period minus one)
//   tick     one-cycle pulse when the count expires
module spi_clk_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             load,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign tick = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      div_d = div;
      cnt_d = div;
    end else if (restart) begin
      cnt_d = div_q;
    end else if (en) begin
      cnt_d = tick ? div_q : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master (any CPOL/CPHA, width, bit order).
// Ports:
//   CLK, RST            system clock, asynchronous active-high reset
//   ClkDiv              SCLK half-period minus one, latched on word accept
//   CsHold              keep SPI_CS_n low after a word and wait for the next one
//   TxData/TxValid/TxReady   word handshake (accept when TxValid && TxReady)
//   RxData/RxValid      received word and its one-cycle update strobe
//   Busy                chip select active or FSM not idle
//   SPI_CS_n, SPI_CLK, SPI_MOSI (registered outputs), SPI_MISO (input)
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV_W     = 8,
  parameter bit          CPOL      = 1'b1,
  parameter bit          CPHA      = 1'b1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DIV_W-1:0]  ClkDiv,
  input  logic              CsHold,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxReady,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              Busy,
  output logic              SPI_CS_n,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  localparam int unsigned CNT_W     = $clog2(2 * DATA_W + 1);
  localparam logic [1:0]  MODE      = {CPOL, CPHA};
  localparam logic        IDLE_HIGH = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
  localparam logic        SHIFT_LEAD = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2 * DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  edge_q, edge_d;

  logic accept, tick, tick_en, restart, edge_go;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign TxReady = !RST && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept  = TxValid && TxReady;
  assign tick_en = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TRAIL);

  spi_clk_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .en      (tick_en),
    .load    (accept),
    .restart (restart),
    .div     (ClkDiv),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    edge_d     = edge_q;
    edge_go    = 1'b0;
    restart    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          // From HOLD this LEAD phase is the inter-word gap; CS is already low.
          state_d = ST_LEAD;
          cs_n_d  = 1'b0;
          edge_d  = '0;
          if (SHIFT_LEAD) begin
            tx_sh_d = TxData;
            mosi_d  = 1'b1;
          end else begin
            // Sample-first modes need the first bit valid before the leading edge.
            mosi_d  = first_bit(TxData);
            tx_sh_d = shift_out(TxData);
          end
        end else if ((state_q == ST_HOLD) && !CsHold) begin
          state_d = ST_TRAIL;
          restart = 1'b1;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d = ST_XFER;
          edge_go = 1'b1;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (edge_q == LAST_EDGE) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            mosi_d     = 1'b1;
            state_d    = CsHold ? ST_HOLD : ST_TRAIL;
          end else begin
            edge_go = 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (edge_go) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + CNT_W'(1);
      // edge_q even means the edge about to happen is a leading edge.
      if ((edge_q[0] == 1'b0) == SHIFT_LEAD) begin
        // The final trailing edge of a sample-first mode has no bit left to shift.
        if (edge_q != PRE_LAST) begin
          mosi_d  = first_bit(tx_sh_q);
          tx_sh_d = shift_out(tx_sh_q);
        end
      end else begin
        rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], SPI_MISO}
                            : {SPI_MISO, rx_sh_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cs_n_q     <= 1'b1;
      sclk_q     <= IDLE_HIGH;
      mosi_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
    end
  end

  assign RxData   = rx_data_q;
  assign RxValid  = rx_valid_q;
  assign Busy     = !cs_n_q || (state_q != ST_IDLE);
  assign SPI_CS_n = cs_n_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed, self-checking bench for spi_master_param.
//   a_*  : mode 3, 8-bit, MSB first, MISO looped back from MOSI
//   g_mode[0..3] : all four modes, 8-bit, slave model returning 8'hC3
//   c_*  : mode 3, 16-bit, LSB first, loopback
module tb_spi_master_param;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic [7:0] a_div = 8'd0, a_tx = 8'd0, a_rx;
  logic a_hold = 1'b0, a_val = 1'b0, a_rdy, a_rxv, a_busy, a_cs, a_sclk, a_mosi;

  spi_master_param #(
    .DATA_W (8), .DIV_W (8), .CPOL (1'b1), .CPHA (1'b1), .MSB_FIRST (1'b1)
  ) u_a (
    .CLK (CLK), .RST (RST), .ClkDiv (a_div), .CsHold (a_hold), .TxData (a_tx),
    .TxValid (a_val), .TxReady (a_rdy), .RxData (a_rx), .RxValid (a_rxv), .Busy (a_busy),
    .SPI_CS_n (a_cs), .SPI_CLK (a_sclk), .SPI_MOSI (a_mosi), .SPI_MISO (a_mosi)
  );

  // ---------------- four modes with a slave model ----------------
  logic [7:0] b_div = 8'd3, b_tx = 8'h3C;
  logic b_val = 1'b0, b_hold = 1'b0;
  logic [3:0] m_sclk, m_rxv;
  logic [7:0] m_rx [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam bit CP = (g >= 2);
    localparam bit CH = (g % 2 == 1);
    logic rdy, rxv, busy, cs, sclk, mosi;
    logic [7:0] rx;
    logic miso = 1'b0;
    logic cs_prev = 1'b1;
    logic [7:0] sw = 8'hC3;
    int scnt = 0;
    int sidx = 0;

    spi_master_param #(
      .DATA_W (8), .DIV_W (8), .CPOL (CP), .CPHA (CH), .MSB_FIRST (1'b1)
    ) u_dut (
      .CLK (CLK), .RST (RST), .ClkDiv (b_div), .CsHold (b_hold), .TxData (b_tx),
      .TxValid (b_val), .TxReady (rdy), .RxData (rx), .RxValid (rxv), .Busy (busy),
      .SPI_CS_n (cs), .SPI_CLK (sclk), .SPI_MOSI (mosi), .SPI_MISO (miso)
    );

    assign m_sclk[g] = sclk;
    assign m_rxv[g]  = rxv;
    assign m_rx[g]   = rx;

    // Slave: presents its MSB at CS fall for CPHA=0, shifts on its shift edges.
    always @(cs or sclk) begin
      if (!cs && cs_prev) begin
        scnt = 0;
        sidx = 0;
        if (!CH) begin
          miso = sw[7-sidx];
          sidx++;
        end
      end else if (!cs) begin
        scnt++;
        if ((((scnt % 2) == 1) == CH) && (sidx < 8)) begin
          miso = sw[7-sidx];
          sidx++;
        end
      end
      cs_prev = cs;
    end
  end

  // ---------------- instance C ----------------
  logic [7:0] c_div = 8'd0;
  logic [15:0] c_tx = 16'd0, c_rx;
  logic c_hold = 1'b0, c_val = 1'b0, c_rdy, c_rxv, c_busy, c_cs, c_sclk, c_mosi;

  spi_master_param #(
    .DATA_W (16), .DIV_W (8), .CPOL (1'b1), .CPHA (1'b1), .MSB_FIRST (1'b0)
  ) u_c (
    .CLK (CLK), .RST (RST), .ClkDiv (c_div), .CsHold (c_hold), .TxData (c_tx),
    .TxValid (c_val), .TxReady (c_rdy), .RxData (c_rx), .RxValid (c_rxv), .Busy (c_busy),
    .SPI_CS_n (c_cs), .SPI_CLK (c_sclk), .SPI_MOSI (c_mosi), .SPI_MISO (c_mosi)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One word on instance A with CsHold=0; cycle 1 is the first cycle after the accept edge.
  task automatic run_word(input logic [7:0] tx, input logic [7:0] div, output logic [7:0] bits,
                          output int rxv_at, output int csh_at, output logic [7:0] rx,
                          output int pulses, output logic cs_low1);
    logic prev;
    int n;
    bits = 8'd0; rxv_at = -1; csh_at = -1; rx = 8'd0; pulses = 0;
    a_tx = tx; a_div = div; a_hold = 1'b0; a_val = 1'b1;
    prev = a_sclk;
    step();
    a_val = 1'b0;
    n = 1;
    cs_low1 = !a_cs;
    while ((n < 6000) && (csh_at < 0)) begin
      if (!prev && a_sclk) bits = {bits[6:0], a_mosi};
      prev = a_sclk;
      if (a_rxv) begin
        pulses++;
        if (rxv_at < 0) begin
          rxv_at = n;
          rx = a_rx;
        end
      end
      if (a_cs) csh_at = n;
      else begin
        step();
        n++;
      end
    end
  endtask

  // Hold-sequence monitor state.
  int   h_pulses;
  logic h_cs_rose;
  logic h_started;
  logic [7:0] h_rx [3];

  task automatic mon_step();
    step();
    if (h_started && a_cs) h_cs_rose = 1'b1;
    if (a_rxv) begin
      if (h_pulses < 3) h_rx[h_pulses] = a_rx;
      h_pulses++;
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] div;
    int         rxv_at;
    int         csh_at;
  } vec_t;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] bits;
  } wvec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [6];
    wvec_t cv [2];
    logic [7:0] bits, rx;
    logic cs_low1, prev, acc;
    int rxv_at, csh_at, pulses, tog, guard, n;
    int tg [4], first [4], bad [4], last [4], rxat [4];
    logic [7:0] rxg [4];
    logic [3:0] prevs;
    int high_run, max_run, p6, nb;
    logic seen_high, rdy_bad;
    logic [7:0] rx6;
    logic [15:0] cbits, crx;

    // Latency = 1 + H + 16*H for RxValid, CS high H cycles later.
    vecs[0] = '{8'hA5, 8'd0, 18, 19};
    vecs[1] = '{8'h3C, 8'd2, 52, 55};
    vecs[2] = '{8'hFF, 8'd1, 35, 37};
    vecs[3] = '{8'h00, 8'd0, 18, 19};
    vecs[4] = '{8'h5A, 8'd7, 137, 145};
    vecs[5] = '{8'h81, 8'd255, 4353, 4609};
    // LSB first; first MOSI bit collected into the MSB of the bit record.
    cv[0] = '{16'h8001, 16'h8001};
    cv[1] = '{16'h0006, 16'h6000};

    // ---- reset state ----
    #1 RST = 1'b1;
    step();
    step();
    check("rst_cs_n", a_cs, 1);
    check("rst_sclk", a_sclk, 1);
    check("rst_mosi", a_mosi, 1);
    check("rst_rxdata", a_rx, 0);
    check("rst_rxvalid", a_rxv, 0);
    check("rst_busy", a_busy, 0);
    check("rst_txready_in_reset", a_rdy, 0);
    check("rst_mode_sclk_idle", m_sclk, 4'b1100);
    RST = 1'b0;
    #1;
    check("rst_txready_after", a_rdy, 1);
    step();

    // ---- reset mid-word after 5 SCLK edges ----
    a_div = 8'd3; a_tx = 8'h0F; a_hold = 1'b0; a_val = 1'b1;
    prev = a_sclk;
    step();
    a_val = 1'b0;
    tog = 0; guard = 0;
    while ((tog < 5) && (guard < 200)) begin
      if (a_sclk != prev) tog++;
      prev = a_sclk;
      if (tog < 5) begin
        step();
        guard++;
      end
    end
    check("midrst_edges_seen", tog, 5);
    check("midrst_sclk_before", a_sclk, 0);
    check("midrst_mosi_before", a_mosi, 0);
    #2 RST = 1'b1;
    #1;
    check("midrst_cs_n", a_cs, 1);
    check("midrst_sclk", a_sclk, 1);
    check("midrst_mosi", a_mosi, 1);
    check("midrst_busy", a_busy, 0);
    step();
    step();
    RST = 1'b0;
    pulses = 0;
    repeat (40) begin
      step();
      if (a_rxv) pulses++;
    end
    check("midrst_no_rxvalid", pulses, 0);
    check("midrst_rxdata", a_rx, 0);

    // ---- table of single words on instance A ----
    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].tx, vecs[i].div, bits, rxv_at, csh_at, rx, pulses, cs_low1);
      check($sformatf("v%0d_cs_low_cycle1", i), cs_low1, 1);
      check($sformatf("v%0d_mosi_bits", i), bits, vecs[i].tx);
      check($sformatf("v%0d_rxdata", i), rx, vecs[i].tx);
      check($sformatf("v%0d_rxvalid_cycle", i), rxv_at, vecs[i].rxv_at);
      check($sformatf("v%0d_cs_high_cycle", i), csh_at, vecs[i].csh_at);
      check($sformatf("v%0d_rxvalid_pulses", i), pulses, 1);
      check($sformatf("v%0d_busy_idle", i), a_busy, 0);
    end
    step();

    // ---- CsHold: three back-to-back words ----
    a_div = 8'd0; a_hold = 1'b1;
    h_pulses = 0; h_cs_rose = 1'b0; h_started = 1'b0;
    for (int w = 0; w < 3; w++) begin
      a_tx = 8'(w + 1);
      a_val = 1'b1;
      acc = 1'b0; guard = 0;
      while (!acc && (guard < 200)) begin
        acc = a_rdy;
        mon_step();
        h_started = 1'b1;
        guard++;
      end
    end
    a_val = 1'b0;
    guard = 0;
    while ((h_pulses < 3) && (guard < 200)) begin
      mon_step();
      guard++;
    end
    check("hold_cs_continuous", h_cs_rose, 0);
    check("hold_pulses", h_pulses, 3);
    check("hold_rx0", h_rx[0], 8'h01);
    check("hold_rx1", h_rx[1], 8'h02);
    check("hold_rx2", h_rx[2], 8'h03);
    // One cycle to leave HOLD, then H=1 cycle of TRAIL.
    a_hold = 1'b0;
    n = 0;
    while (!a_cs && (n < 50)) begin
      step();
      n++;
    end
    check("hold_cs_rise_cycles", n, 2);

    // ---- TxValid held through TRAIL ----
    step();
    a_div = 8'd1; a_tx = 8'h5A; a_val = 1'b1;
    p6 = 0; high_run = 0; max_run = 0; seen_high = 1'b0; rdy_bad = 1'b0; rx6 = 8'd0;
    guard = 0;
    while ((p6 < 2) && (guard < 300)) begin
      step();
      guard++;
      if (a_rxv) begin
        p6++;
        rx6 = a_rx;
      end
      if (p6 == 1) begin
        if (a_cs) begin
          seen_high = 1'b1;
          high_run++;
          if (high_run > max_run) max_run = high_run;
        end else begin
          high_run = 0;
          if (!seen_high && a_rdy) rdy_bad = 1'b1;
        end
      end
    end
    a_val = 1'b0;
    check("trail_two_words", p6, 2);
    check("trail_txready_low", rdy_bad, 0);
    check("trail_cs_high_run", max_run, 1);
    check("trail_rx_second", rx6, 8'h5A);
    guard = 0;
    while (!a_cs && (guard < 100)) begin
      step();
      guard++;
    end

    // ---- all four modes, ClkDiv=3 ----
    for (int g = 0; g < 4; g++) begin
      tg[g] = 0; first[g] = 0; bad[g] = 0; last[g] = 0; rxat[g] = 0; rxg[g] = 8'd0;
    end
    prevs = m_sclk;
    b_val = 1'b1;
    step();
    b_val = 1'b0;
    for (int k = 1; k < 200; k++) begin
      for (int g = 0; g < 4; g++) begin
        if (m_sclk[g] != prevs[g]) begin
          if (tg[g] == 0) first[g] = k;
          else if ((k - last[g]) != 4) bad[g]++;
          last[g] = k;
          tg[g]++;
        end
        if (m_rxv[g] && (rxat[g] == 0)) begin
          rxat[g] = k;
          rxg[g] = m_rx[g];
        end
      end
      prevs = m_sclk;
      step();
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("mode%0d_rxdata", g), rxg[g], 8'hC3);
      check($sformatf("mode%0d_rxvalid_cycle", g), rxat[g], 69);
      check($sformatf("mode%0d_edges", g), tg[g], 16);
      check($sformatf("mode%0d_first_edge", g), first[g], 5);
      check($sformatf("mode%0d_level_len", g), bad[g], 0);
    end
    check("mode_sclk_idle_after", m_sclk, 4'b1100);

    // ---- 16-bit LSB-first ----
    for (int i = 0; i < 2; i++) begin
      c_tx = cv[i].tx;
      c_val = 1'b1;
      prev = c_sclk;
      step();
      c_val = 1'b0;
      cbits = 16'd0; nb = 0; rxv_at = -1; crx = 16'd0;
      for (int k = 1; k < 200; k++) begin
        if (!prev && c_sclk) begin
          cbits = {cbits[14:0], c_mosi};
          nb++;
        end
        prev = c_sclk;
        if (c_rxv && (rxv_at < 0)) begin
          rxv_at = k;
          crx = c_rx;
        end
        step();
      end
      check($sformatf("w16_%0d_nbits", i), nb, 16);
      check($sformatf("w16_%0d_mosi_bits", i), cbits, cv[i].bits);
      check($sformatf("w16_%0d_rxdata", i), crx, cv[i].tx);
      check($sformatf("w16_%0d_rxvalid_cycle", i), rxv_at, 34);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
